piso_stream: RTL and testbench

- Parametrised parallel-in/serial-out converter between a parallel-word FIFO and a narrower streaming datapath.
- Each IN_WIDTH word read from the FIFO is emitted as N = IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH slices.
- Adds downstream backpressure (valid/ready), a selectable slice order, a per-word last flag and a one-word prefetch. With a non-empty FIFO and ready held high, output is gap-free.
- Sits between the DRAM/dedispersion read FIFO and the 10GbE packetiser.

---
 rtl/piso_stream_if.sv | 25 ++
 rtl/piso_stream.sv | 102 ++++++++++
 tb/tb_piso_stream.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_stream_if.sv
// Bundles the FIFO read side and the serial stream side of piso_stream.
// The master modport is the converter's view; slave is the environment's.
interface piso_stream_if #(
    parameter int IN_WIDTH  = 1024,
    parameter int OUT_WIDTH = 64
);
    logic [IN_WIDTH-1:0]  i_parallel;
    logic                 fifo_empty;
    logic                 fifo_re;
    logic [OUT_WIDTH-1:0] o_serial;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;
    logic                 o_busy;

    modport master (
        input  i_parallel, fifo_empty, i_ready,
        output fifo_re, o_serial, o_valid, o_last, o_busy
    );

    modport slave (
        output i_parallel, fifo_empty, i_ready,
        input  fifo_re, o_serial, o_valid, o_last, o_busy
    );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out converter: each IN_WIDTH FIFO word is streamed as
// IN_WIDTH/OUT_WIDTH slices with valid/ready backpressure, a per-word last
// flag and a one-word prefetch register so the stream stays gap-free.
//
// Storage: H holds the word being streamed (shifted one slice per transfer),
// P holds a prefetched word. At most one FIFO read is outstanding; a read is
// only issued while P is empty, so arriving data always has a free slot.
module piso_stream #(
    parameter int IN_WIDTH     = 1024,
    parameter int OUT_WIDTH    = 64,
    parameter bit MSB_FIRST    = 1'b0,
    parameter int FIFO_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    piso_stream_if.master bus
);
    localparam int N  = IN_WIDTH / OUT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam bit REG_RD = (FIFO_LATENCY == 1);

    if ((OUT_WIDTH < 1) || (IN_WIDTH < 2 * OUT_WIDTH) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_width
        $error("piso_stream: IN_WIDTH must be an integer multiple (>= 2) of OUT_WIDTH");
    end
    if ((FIFO_LATENCY != 0) && (FIFO_LATENCY != 1)) begin : g_bad_latency
        $error("piso_stream: FIFO_LATENCY must be 0 or 1");
    end

    logic [IN_WIDTH-1:0] h_data;
    logic [IN_WIDTH-1:0] p_data;
    logic [IN_WIDTH-1:0] h_shift;
    logic                h_valid;
    logic                p_valid;
    logic                pend;
    logic [CW-1:0]       cnt;

    logic xfer;
    logic word_end;
    logic h_free;
    logic rd_en;
    logic arrive;

    assign xfer     = ce & h_valid & bus.i_ready;
    assign word_end = xfer & (cnt == LAST_IDX);
    // H can take new data if empty, or if its last slice leaves now with no prefetch to replace it.
    assign h_free   = ~h_valid | (word_end & ~p_valid);
    assign rd_en    = ce & ~rst & ~bus.fifo_empty & ~pend & ~p_valid;
    // With a registered FIFO the data shows up the cycle after the read; FWFT data is valid with the read.
    assign arrive   = REG_RD ? pend : rd_en;

    // Slice order is set by which end of H is presented and which way it shifts.
    if (MSB_FIRST) begin : g_msb
        assign h_shift      = h_data << OUT_WIDTH;
        assign bus.o_serial = h_data[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
        assign h_shift      = h_data >> OUT_WIDTH;
        assign bus.o_serial = h_data[OUT_WIDTH-1:0];
    end

    assign bus.fifo_re = rd_en;
    assign bus.o_valid = h_valid;
    assign bus.o_last  = h_valid & (cnt == LAST_IDX);
    assign bus.o_busy  = h_valid | p_valid | pend;

    // Slice counter, hold/prefetch registers and read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_data  <= '0;
            p_data  <= '0;
            h_valid <= 1'b0;
            p_valid <= 1'b0;
            pend    <= 1'b0;
            cnt     <= '0;
        end else begin
            pend <= REG_RD & rd_en;

            if (xfer) begin
                cnt <= word_end ? '0 : cnt + 1'b1;
            end

            if (xfer && !word_end) begin
                h_data <= h_shift;
            end else if (word_end && p_valid) begin
                h_data  <= p_data;
                p_valid <= 1'b0;
            end else if (arrive && h_free) begin
                h_data  <= bus.i_parallel;
                h_valid <= 1'b1;
            end else if (word_end) begin
                h_valid <= 1'b0;
            end

            // Data arriving while H is still busy parks in P, even with ce low.
            if (arrive && !h_free) begin
                p_data  <= bus.i_parallel;
                p_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: two instances (256/64 LSB-first registered FIFO,
// 1024/64 MSB-first fall-through FIFO) share control inputs. A FIFO model
// feeds each; words are queued as expectations on enqueue and a monitor
// checks every accepted slice, hold behaviour and o_busy.
module tb_piso_stream;
    localparam int IW0 = 256;
    localparam int IW1 = 1024;
    localparam int OW  = 64;
    localparam int N0  = IW0 / OW;
    localparam int N1  = IW1 / OW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;

    piso_stream_if #(.IN_WIDTH(IW0), .OUT_WIDTH(OW)) bus0 ();
    piso_stream_if #(.IN_WIDTH(IW1), .OUT_WIDTH(OW)) bus1 ();

    piso_stream #(.IN_WIDTH(IW0), .OUT_WIDTH(OW), .MSB_FIRST(1'b0), .FIFO_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .bus(bus0)
    );
    piso_stream #(.IN_WIDTH(IW1), .OUT_WIDTH(OW), .MSB_FIRST(1'b1), .FIFO_LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .bus(bus1)
    );

    always #5 clk = ~clk;

    logic [1023:0] q0[$], q1[$], e0[$], e1[$];
    logic [1023:0] lat_w;
    logic          lat_v = 1'b0;
    logic          after_rst = 1'b0;
    logic          rst_c, ce_c, rdy_c, stall_c;
    logic          rand_mode = 1'b0;
    logic          mon_en = 1'b0;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            rd[2], done[2], rd_seen[2], sidx[2], xf[2];
    int            first_v[2], first_x[2], last_x[2], re_cyc[2];
    logic          re_now[2];
    logic          pv[2], pr[2], pce[2], prst[2], pl[2];
    logic [63:0]   ps[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1023:0] rnd_word();
        logic [1023:0] w;
        for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Reference: slice k of a word in emission order.
    function automatic logic [63:0] slice_of(input logic [1023:0] w, input int k, input int n, input bit msb);
        int idx;
        idx = msb ? (n - 1 - k) : k;
        return w[idx*64 +: 64];
    endfunction

    task automatic push(input int d, input logic [1023:0] w);
        if (d == 0) begin q0.push_back(w); e0.push_back(w); end
        else        begin q1.push_back(w); e1.push_back(w); end
    endtask

    // One clock of stimulus: drive at negedge, observe fifo_re 1 ns later.
    task automatic cycle();
        logic [1023:0] junk;
        @(negedge clk);
        cyc++;
        if (rand_mode) begin
            rdy_c   = ($urandom_range(0, 3) != 0);
            ce_c    = ($urandom_range(0, 9) != 0);
            stall_c = ($urandom_range(0, 4) == 0);
        end
        junk = rnd_word();
        rst  = rst_c;
        ce   = ce_c;
        bus0.i_ready    = rdy_c;
        bus1.i_ready    = rdy_c;
        bus0.fifo_empty = (q0.size() == 0) || stall_c;
        bus0.i_parallel = lat_v ? lat_w[IW0-1:0] : junk[IW0-1:0];
        bus1.fifo_empty = (q1.size() == 0) || stall_c;
        bus1.i_parallel = (q1.size() != 0) ? q1[0] : junk;
        #1;
        re_now[0] = bus0.fifo_re;
        re_now[1] = bus1.fifo_re;
        if (after_rst) begin
            chk("post_rst_valid[0]", 64'(bus0.o_valid), 64'd0);
            chk("post_rst_busy[0]", 64'(bus0.o_busy), 64'd0);
            chk("post_rst_valid[1]", 64'(bus1.o_valid), 64'd0);
            chk("post_rst_busy[1]", 64'(bus1.o_busy), 64'd0);
        end
        after_rst = rst;
        if (re_now[0]) begin
            chk("re_legal[0]", 64'({bus0.fifo_empty, rst, !ce, lat_v}), 64'd0);
            if (re_cyc[0] < 0) re_cyc[0] = cyc;
            if (q0.size() != 0) begin lat_w = q0.pop_front(); rd[0]++; end
            lat_v = 1'b1;
        end else begin
            lat_v = 1'b0;
        end
        if (re_now[1]) begin
            chk("re_legal[1]", 64'({bus1.fifo_empty, rst, !ce}), 64'd0);
            if (re_cyc[1] < 0) re_cyc[1] = cyc;
            if (q1.size() != 0) begin void'(q1.pop_front()); rd[1]++; end
        end
    endtask

    task automatic mon(input int d, input logic v, input logic l, input logic [63:0] s,
                       input logic b, input logic r);
        int n;
        logic msb, has, hold;
        logic [1023:0] w;
        n    = (d == 0) ? N0 : N1;
        msb  = (d == 1);
        hold = pv[d] && !prst[d] && !(pce[d] && pr[d]);
        if (hold) begin
            chk($sformatf("hold_valid[%0d]", d), 64'(v), 64'd1);
            chk($sformatf("hold_serial[%0d]", d), s, ps[d]);
            chk($sformatf("hold_last[%0d]", d), 64'(l), 64'(pl[d]));
        end
        chk($sformatf("busy[%0d]", d), 64'(b), 64'(rd_seen[d] > done[d]));
        if (!v) chk($sformatf("last_without_valid[%0d]", d), 64'(l), 64'd0);
        if (rst) begin
            for (int i = done[d]; i < rd[d]; i++) begin
                if (d == 0) void'(e0.pop_front()); else void'(e1.pop_front());
            end
            done[d] = rd[d];
            sidx[d] = 0;
        end else if (ce && v && r) begin
            has = (d == 0) ? (e0.size() != 0) : (e1.size() != 0);
            if (!has) begin
                chk($sformatf("unexpected_slice[%0d]", d), 64'(v && has), 64'd0);
            end else begin
                w = (d == 0) ? e0[0] : e1[0];
                chk($sformatf("slice[%0d]", d), s, slice_of(w, sidx[d], n, msb));
                chk($sformatf("last[%0d]", d), 64'(l), 64'(sidx[d] == n - 1));
                xf[d]++;
                if (first_x[d] < 0) first_x[d] = cyc;
                last_x[d] = cyc;
                sidx[d]++;
                if (sidx[d] == n) begin
                    sidx[d] = 0;
                    done[d]++;
                    if (d == 0) void'(e0.pop_front()); else void'(e1.pop_front());
                end
            end
        end
        if (v && first_v[d] < 0) first_v[d] = cyc;
        pv[d] = v; ps[d] = s; pl[d] = l; pr[d] = r; pce[d] = ce; prst[d] = rst;
        rd_seen[d] = rd[d];
    endtask

    // Monitor: checks whatever the DUTs present, independent of stimulus.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            mon(0, bus0.o_valid, bus0.o_last, bus0.o_serial, bus0.o_busy, bus0.i_ready);
            mon(1, bus1.o_valid, bus1.o_last, bus1.o_serial, bus1.o_busy, bus1.i_ready);
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && e0.size() == 0 && e1.size() == 0
                 && !bus0.o_busy && !bus1.o_busy) && k < budget) begin
            cycle();
            k++;
        end
        chk({"idle_", name}, 64'(k < budget), 64'd1);
    endtask

    task automatic mark();
        for (int d = 0; d < 2; d++) begin
            first_v[d] = -1; re_cyc[d] = -1; first_x[d] = -1; last_x[d] = -1; xf[d] = 0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] w;
        int rd0, rd1, k;
        logic hit;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; done[d] = 0; rd_seen[d] = 0; sidx[d] = 0;
            pv[d] = 1'b0; pr[d] = 1'b0; pce[d] = 1'b0; prst[d] = 1'b1; pl[d] = 1'b0; ps[d] = '0;
            re_now[d] = 1'b0;
        end
        mark();
        bus0.i_ready = 1'b1; bus1.i_ready = 1'b1;
        bus0.fifo_empty = 1'b1; bus1.fifo_empty = 1'b1;
        bus0.i_parallel = '0; bus1.i_parallel = '0;
        rst_c = 1'b1; ce_c = 1'b1; rdy_c = 1'b1; stall_c = 1'b0;

        // Reset state.
        repeat (3) cycle();
        chk("rst_valid[0]", 64'(bus0.o_valid), 64'd0);
        chk("rst_last[0]", 64'(bus0.o_last), 64'd0);
        chk("rst_re[0]", 64'(bus0.fifo_re), 64'd0);
        chk("rst_busy[0]", 64'(bus0.o_busy), 64'd0);
        chk("rst_serial[0]", bus0.o_serial, 64'd0);
        chk("rst_valid[1]", 64'(bus1.o_valid), 64'd0);
        chk("rst_last[1]", 64'(bus1.o_last), 64'd0);
        chk("rst_re[1]", 64'(bus1.fifo_re), 64'd0);
        chk("rst_busy[1]", 64'(bus1.o_busy), 64'd0);
        chk("rst_serial[1]", bus1.o_serial, 64'd0);
        mon_en = 1'b1;
        rst_c = 1'b0;

        // Single known word from idle: latency and slice order.
        mark();
        w = '0;
        for (int i = 0; i < 4; i++) w[i*64 +: 64] = 64'(i + 1);
        push(0, w);
        w = '0;
        for (int i = 0; i < 16; i++) w[i*64 +: 64] = 64'(i + 1);
        push(1, w);
        wait_idle("single", 200);
        chk("latency[0]", 64'(first_v[0] - re_cyc[0]), 64'd2);
        chk("latency[1]", 64'(first_v[1] - re_cyc[1]), 64'd1);
        chk("single_slices[0]", 64'(xf[0]), 64'(N0));
        chk("single_slices[1]", 64'(xf[1]), 64'(N1));

        // Three words back to back: gap-free stream, one read per word.
        mark();
        rd0 = rd[0]; rd1 = rd[1];
        for (int i = 0; i < 3; i++) begin push(0, rnd_word()); push(1, rnd_word()); end
        wait_idle("b2b", 300);
        chk("b2b_slices[0]", 64'(xf[0]), 64'(3 * N0));
        chk("b2b_span[0]", 64'(last_x[0] - first_x[0] + 1), 64'(xf[0]));
        chk("b2b_reads[0]", 64'(rd[0] - rd0), 64'd3);
        chk("b2b_slices[1]", 64'(xf[1]), 64'(3 * N1));
        chk("b2b_span[1]", 64'(last_x[1] - first_x[1] + 1), 64'(xf[1]));
        chk("b2b_reads[1]", 64'(rd[1] - rd1), 64'd3);

        // Reset in the cycle after a read issued mid-word; later words restart at slice 0.
        mark();
        for (int i = 0; i < 4; i++) begin push(0, rnd_word()); push(1, rnd_word()); end
        hit = 1'b0;
        k = 0;
        while (!hit && k < 100) begin
            cycle();
            k++;
            hit = (xf[0] >= 2) && re_now[0];
        end
        chk("rst_trigger", 64'(hit), 64'd1);
        rst_c = 1'b1;
        cycle();
        rst_c = 1'b0;
        wait_idle("midrst", 400);

        // Clock enable low for five cycles mid-word.
        mark();
        for (int i = 0; i < 2; i++) begin push(0, rnd_word()); push(1, rnd_word()); end
        k = 0;
        while (xf[1] < 3 && k < 100) begin cycle(); k++; end
        chk("ce_trigger", 64'(xf[1] >= 3), 64'd1);
        ce_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("ce_low_re[0]", 64'(bus0.fifo_re), 64'd0);
            chk("ce_low_re[1]", 64'(bus1.fifo_re), 64'd0);
        end
        ce_c = 1'b1;
        wait_idle("ce", 400);
        chk("ce_slices[0]", 64'(xf[0]), 64'(2 * N0));
        chk("ce_slices[1]", 64'(xf[1]), 64'(2 * N1));

        // Random backpressure, clock enable and FIFO stalls.
        mark();
        for (int i = 0; i < 40; i++) begin push(0, rnd_word()); push(1, rnd_word()); end
        rand_mode = 1'b1;
        wait_idle("random", 6000);
        rand_mode = 1'b0;
        rdy_c = 1'b1; ce_c = 1'b1; stall_c = 1'b0;
        chk("rand_slices[0]", 64'(xf[0]), 64'(40 * N0));
        chk("rand_slices[1]", 64'(xf[1]), 64'(40 * N1));
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
